// File: rtl/tile_window_loader_if.sv
// ---------------------------------------------------------------------------
// tile_window_loader_if
// Bundles the pixel-beat input channel and the 3x3 window output channel of
// tile_window_loader.
//   in_valid / load_end / pixel_in0..4 / in_ready : pixel beat channel
//   win_valid / win_data / win_last / win_ready    : window channel
//   tile_done / tile_err                           : per-tile status pulses
// Modports:
//   master : the environment (beat source and window sink)
//   slave  : the loader itself
// ---------------------------------------------------------------------------
interface tile_window_loader_if #(
    parameter int BIT_LENGTH = 4
);
    logic                      in_valid;
    logic [BIT_LENGTH-1:0]     pixel_in0;
    logic [BIT_LENGTH-1:0]     pixel_in1;
    logic [BIT_LENGTH-1:0]     pixel_in2;
    logic [BIT_LENGTH-1:0]     pixel_in3;
    logic [BIT_LENGTH-1:0]     pixel_in4;
    logic                      load_end;
    logic                      in_ready;
    logic                      win_valid;
    logic                      win_ready;
    logic [9*BIT_LENGTH-1:0]   win_data;
    logic                      win_last;
    logic                      tile_done;
    logic                      tile_err;

    modport master (
        output in_valid, pixel_in0, pixel_in1, pixel_in2, pixel_in3, pixel_in4,
               load_end, win_ready,
        input  in_ready, win_valid, win_data, win_last, tile_done, tile_err
    );

    modport slave (
        input  in_valid, pixel_in0, pixel_in1, pixel_in2, pixel_in3, pixel_in4,
               load_end, win_ready,
        output in_ready, win_valid, win_data, win_last, tile_done, tile_err
    );
endinterface

// File: rtl/tile_window_loader.sv
// ---------------------------------------------------------------------------
// tile_window_loader
// Captures a TILE x TILE tile of BIT_LENGTH-bit pixels, LANES pixels per beat,
// into an internal buffer, then streams every 3x3 neighbourhood in raster
// order over a valid/ready handshake. Loading and streaming alternate.
// Ports:
//   clk    : clock, all state on rising edge
//   reset  : asynchronous, active-high
//   io_bus : tile_window_loader_if.slave (beat input, window output, status)
// ---------------------------------------------------------------------------
module tile_window_loader #(
    parameter int BIT_LENGTH = 4,
    parameter int TILE       = 20,
    // The interface carries exactly five pixel lanes, so LANES must stay 5.
    parameter int LANES      = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    tile_window_loader_if.slave   io_bus
);
    localparam int BEATS = TILE * TILE / LANES;
    localparam int OUTW  = TILE - 2;
    localparam int PIXW  = $clog2(TILE * TILE);
    localparam int BEATW = $clog2(BEATS);
    localparam int RCW   = $clog2(TILE);

    typedef enum logic [1:0] {IDLE, LOAD, STREAM} state_t;

    state_t                  r_state;
    state_t                  w_nextState;
    logic [BEATW-1:0]        r_beat;
    logic [RCW-1:0]          r_row;
    logic [RCW-1:0]          r_col;
    logic                    r_tileDone;
    logic                    r_tileErr;
    logic [BIT_LENGTH-1:0]   r_pix [TILE][TILE];

    logic [BIT_LENGTH-1:0]   w_lane    [LANES];
    logic [PIXW-1:0]         w_laneIdx [LANES];
    logic [RCW-1:0]          w_laneRow [LANES];
    logic [RCW-1:0]          w_laneCol [LANES];
    logic                    w_accept;
    logic                    w_lastBeat;
    logic                    w_early;
    logic                    w_handshake;
    logic                    w_lastWin;
    logic                    w_inReady;
    logic                    w_winValid;
    logic                    w_winLast;
    logic [9*BIT_LENGTH-1:0] w_winData;

    assign w_lane[0] = io_bus.pixel_in0;
    assign w_lane[1] = io_bus.pixel_in1;
    assign w_lane[2] = io_bus.pixel_in2;
    assign w_lane[3] = io_bus.pixel_in3;
    assign w_lane[4] = io_bus.pixel_in4;

    assign w_accept    = io_bus.in_valid && w_inReady;
    assign w_lastBeat  = (r_beat == BEATW'(BEATS - 1));
    // load_end on any beat but the last one aborts the tile.
    assign w_early     = w_accept && io_bus.load_end && !w_lastBeat;
    assign w_handshake = w_winValid && io_bus.win_ready;
    assign w_lastWin   = (r_row == RCW'(OUTW - 1)) && (r_col == RCW'(OUTW - 1));

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. The beat counter is 0 whenever we sit in IDLE, so
    // IDLE and LOAD share the same transitions.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE, LOAD: begin
                if (w_accept) begin
                    if (w_lastBeat) begin
                        w_nextState = STREAM;
                    end else if (io_bus.load_end) begin
                        w_nextState = IDLE;
                    end else begin
                        w_nextState = LOAD;
                    end
                end
            end
            STREAM: begin
                if (w_handshake && w_lastWin) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        w_inReady  = (r_state != STREAM);
        w_winValid = (r_state == STREAM);
        w_winLast  = w_winValid && w_lastWin;
    end

    // Beat counter, window position and status pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_beat     <= '0;
            r_row      <= '0;
            r_col      <= '0;
            r_tileDone <= 1'b0;
            r_tileErr  <= 1'b0;
        end else begin
            r_tileDone <= w_handshake && w_lastWin;
            r_tileErr  <= w_early;
            if (w_accept) begin
                r_beat <= (w_lastBeat || io_bus.load_end) ? '0 : r_beat + BEATW'(1);
            end
            if (w_handshake) begin
                if (r_col == RCW'(OUTW - 1)) begin
                    r_col <= '0;
                    r_row <= w_lastWin ? '0 : r_row + RCW'(1);
                end else begin
                    r_col <= r_col + RCW'(1);
                end
            end
        end
    end

    // Linear pixel index of each lane in the current beat, split into row/column.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            w_laneIdx[l] = PIXW'(r_beat) * PIXW'(LANES) + PIXW'(l);
            w_laneRow[l] = RCW'(w_laneIdx[l] / PIXW'(TILE));
            w_laneCol[l] = RCW'(w_laneIdx[l] % PIXW'(TILE));
        end
    end

    // Tile buffer: contents are don't-care after reset, so it has none.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int l = 0; l < LANES; l++) begin
                r_pix[w_laneRow[l]][w_laneCol[l]] <= w_lane[l];
            end
        end
    end

    // Window selection straight from the buffer. The buffer is frozen while
    // streaming and r_row/r_col only move on a handshake, so the data is held
    // stable during stalls without an extra register stage.
    always_comb begin
        w_winData = '0;
        if (w_winValid) begin
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    w_winData[BIT_LENGTH*(3*i+j) +: BIT_LENGTH] =
                        r_pix[r_row + RCW'(i)][r_col + RCW'(j)];
                end
            end
        end
    end

    assign io_bus.in_ready  = w_inReady;
    assign io_bus.win_valid = w_winValid;
    assign io_bus.win_data  = w_winData;
    assign io_bus.win_last  = w_winLast;
    assign io_bus.tile_done = r_tileDone;
    assign io_bus.tile_err  = r_tileErr;
endmodule

// File: tb/tb_tile_window_loader.sv
// ---------------------------------------------------------------------------
// tb_tile_window_loader
// Directed bench for tile_window_loader: loads tiles from a bench-side pixel
// array and compares every streamed window with a window built from that array.
// ---------------------------------------------------------------------------
module tb_tile_window_loader;
    logic clk;
    logic reset;
    int   compareCount;
    int   mismatchCount;

    logic [3:0] tbPix [20][20];

    tile_window_loader_if #(.BIT_LENGTH(4)) bus ();

    tile_window_loader #(
        .BIT_LENGTH(4),
        .TILE(20),
        .LANES(5)
    ) dut (
        .clk(clk),
        .reset(reset),
        .io_bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [35:0] observed, input logic [35:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic logic [3:0] lanePix(input int k, input int l);
        int idx;
        idx = k * 5 + l;
        return tbPix[idx / 20][idx % 20];
    endfunction

    function automatic logic [35:0] expWindow(input int r, input int c);
        logic [35:0] w;
        w = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                w[4*(3*i+j) +: 4] = tbPix[r+i][c+j];
            end
        end
        return w;
    endfunction

    task automatic fillTile(input int mode);
        for (int r = 0; r < 20; r++) begin
            for (int c = 0; c < 20; c++) begin
                case (mode)
                    0:       tbPix[r][c] = 4'((r + c) % 16);
                    1:       tbPix[r][c] = 4'(r % 16);
                    default: tbPix[r][c] = 4'($urandom_range(0, 15));
                endcase
            end
        end
    endtask

    // Drives one tile of beats. errBeat >= 0 raises load_end early on that beat.
    // gapA/gapB insert 3 idle cycles after those beats. endFlag sets load_end on beat 79.
    task automatic applyStimulus(input int errBeat, input int gapA, input int gapB, input bit endFlag);
        for (int k = 0; k < 80; k++) begin
            bus.in_valid  = 1'b1;
            bus.pixel_in0 = lanePix(k, 0);
            bus.pixel_in1 = lanePix(k, 1);
            bus.pixel_in2 = lanePix(k, 2);
            bus.pixel_in3 = lanePix(k, 3);
            bus.pixel_in4 = lanePix(k, 4);
            bus.load_end  = (k == errBeat) || (k == 79 && endFlag);
            checkOutput("inReadyLoad", 36'(bus.in_ready), 36'd1);
            checkOutput("tileErrQuiet", 36'(bus.tile_err), 36'd0);
            @(posedge clk);
            #1;
            if (k == errBeat) begin
                bus.in_valid = 1'b0;
                bus.load_end = 1'b0;
                checkOutput("tileErrPulse", 36'(bus.tile_err), 36'd1);
                checkOutput("inReadyAfterErr", 36'(bus.in_ready), 36'd1);
                checkOutput("noWinAfterErr", 36'(bus.win_valid), 36'd0);
                @(posedge clk);
                #1;
                checkOutput("tileErrOnce", 36'(bus.tile_err), 36'd0);
                checkOutput("noWinAfterErr2", 36'(bus.win_valid), 36'd0);
                return;
            end
            if (k == gapA || k == gapB) begin
                bus.in_valid = 1'b0;
                bus.load_end = 1'b1;
                bus.pixel_in0 = 4'hF;
                bus.pixel_in1 = 4'hE;
                bus.pixel_in2 = 4'hD;
                bus.pixel_in3 = 4'hC;
                bus.pixel_in4 = 4'hB;
                repeat (3) begin
                    @(posedge clk);
                    #1;
                end
                checkOutput("gapNoErr", 36'(bus.tile_err), 36'd0);
            end
        end
        bus.in_valid = 1'b0;
        bus.load_end = 1'b0;
        checkOutput("winValidLatency", 36'(bus.win_valid), 36'd1);
        checkOutput("inReadyStream", 36'(bus.in_ready), 36'd0);
    endtask

    // Consumes the windows of one tile. mode 0: always ready, 1: 1010.. with a
    // 5-cycle stall at window 50, 2: random. abortAt >= 0 pulses reset at that window.
    task automatic drainWindows(input int mode, input int abortAt,
                                output logic [35:0] firstWin, output logic [35:0] lastWin);
        int          n;
        int          cyc;
        int          stalled;
        logic        rdy;
        logic [35:0] held;
        logic        heldLast;
        n        = 0;
        cyc      = 0;
        stalled  = 0;
        firstWin = '0;
        lastWin  = '0;
        while (n < 324 && cyc < 3000) begin
            case (mode)
                0: rdy = 1'b1;
                1: begin
                    if (n == 50 && stalled < 5) begin
                        rdy = 1'b0;
                        stalled++;
                    end else begin
                        rdy = (cyc % 2 == 0);
                    end
                end
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            bus.win_ready = rdy;
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.load_end  = 1'($urandom_range(0, 1));
            bus.pixel_in0 = 4'($urandom_range(0, 15));
            bus.pixel_in4 = 4'($urandom_range(0, 15));
            if (abortAt >= 0 && n == abortAt) begin
                bus.in_valid  = 1'b0;
                bus.load_end  = 1'b0;
                bus.win_ready = 1'b0;
                #2;
                reset = 1'b1;
                #1;
                checkOutput("abortWinValid", 36'(bus.win_valid), 36'd0);
                checkOutput("abortInReady", 36'(bus.in_ready), 36'd1);
                checkOutput("abortWinData", bus.win_data, 36'd0);
                checkOutput("abortWinLast", 36'(bus.win_last), 36'd0);
                @(negedge clk);
                reset = 1'b0;
                @(posedge clk);
                #1;
                return;
            end
            checkOutput("streamNoDone", 36'(bus.tile_done), 36'd0);
            checkOutput("streamValid", 36'(bus.win_valid), 36'd1);
            checkOutput("winData", bus.win_data, expWindow(n / 18, n % 18));
            checkOutput("winLast", 36'(bus.win_last), 36'(n == 323));
            if (n == 0)   firstWin = bus.win_data;
            if (n == 323) lastWin  = bus.win_data;
            held     = bus.win_data;
            heldLast = bus.win_last;
            @(posedge clk);
            #1;
            cyc++;
            if (rdy) begin
                n++;
            end else begin
                checkOutput("stallData", bus.win_data, held);
                checkOutput("stallLast", 36'(bus.win_last), 36'(heldLast));
            end
        end
        bus.in_valid  = 1'b0;
        bus.load_end  = 1'b0;
        bus.win_ready = 1'b0;
        if (n < 324) begin
            checkOutput("drainTimeout", 36'(n), 36'd324);
        end else begin
            checkOutput("tileDonePulse", 36'(bus.tile_done), 36'd1);
            checkOutput("doneWinValid", 36'(bus.win_valid), 36'd0);
            checkOutput("doneInReady", 36'(bus.in_ready), 36'd1);
        end
    endtask

    initial begin
        logic [35:0] firstWin;
        logic [35:0] lastWin;
        compareCount  = 0;
        mismatchCount = 0;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.load_end  = 1'b0;
        bus.win_ready = 1'b0;
        bus.pixel_in0 = '0;
        bus.pixel_in1 = '0;
        bus.pixel_in2 = '0;
        bus.pixel_in3 = '0;
        bus.pixel_in4 = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rstInReady", 36'(bus.in_ready), 36'd1);
        checkOutput("rstWinValid", 36'(bus.win_valid), 36'd0);
        checkOutput("rstWinData", bus.win_data, 36'd0);
        checkOutput("rstWinLast", 36'(bus.win_last), 36'd0);
        checkOutput("rstTileDone", 36'(bus.tile_done), 36'd0);
        checkOutput("rstTileErr", 36'(bus.tile_err), 36'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] T1 gradient tile, always ready");
        fillTile(0);
        applyStimulus(-1, -1, -1, 1'b1);
        drainWindows(0, -1, firstWin, lastWin);
        checkOutput("t1Win00", firstWin, 36'h432321210);
        checkOutput("t1Win1717", lastWin, 36'h654543432);

        $display("[TB] T2 toggled ready with stall");
        applyStimulus(-1, -1, -1, 1'b0);
        drainWindows(1, -1, firstWin, lastWin);
        checkOutput("t2Win00", firstWin, 36'h432321210);

        $display("[TB] T3 premature load_end");
        applyStimulus(40, -1, -1, 1'b1);
        applyStimulus(-1, -1, -1, 1'b1);
        drainWindows(0, -1, firstWin, lastWin);
        checkOutput("t3Win1717", lastWin, 36'h654543432);

        $display("[TB] T4 input gaps");
        applyStimulus(-1, 10, 63, 1'b1);
        drainWindows(0, -1, firstWin, lastWin);
        checkOutput("t4Win1717", lastWin, 36'h654543432);

        $display("[TB] T5 reset mid-stream");
        applyStimulus(-1, -1, -1, 1'b1);
        drainWindows(0, 100, firstWin, lastWin);
        fillTile(1);
        applyStimulus(-1, -1, -1, 1'b1);
        drainWindows(0, -1, firstWin, lastWin);
        checkOutput("t5Win00", firstWin, 36'h222111000);

        $display("[TB] T6 back-to-back random tiles");
        fillTile(2);
        applyStimulus(-1, -1, -1, 1'b1);
        drainWindows(2, -1, firstWin, lastWin);
        fillTile(2);
        applyStimulus(-1, -1, -1, 1'b1);
        drainWindows(2, -1, firstWin, lastWin);
        @(posedge clk);
        #1;
        checkOutput("finalDoneLow", 36'(bus.tile_done), 36'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end
endmodule
